// File: rtl/alu_pkg.sv
// Shared constants for the ALU sharing arbiter: widths, opcodes, flag bit
// positions and the requester port identifier.
package alu_pkg;

  localparam int ALU_DW  = 16;
  localparam int ALU_OPW = 5;

  localparam logic [4:0] OP_NOP  = 5'b00001;
  localparam logic [4:0] OP_ADDI = 5'b01000;
  localparam logic [4:0] OP_SUB  = 5'b11011;

  // Bit positions inside the {Zero, Pos, Neg} flag vector.
  localparam int FLAG_ZERO = 2;
  localparam int FLAG_POS  = 1;
  localparam int FLAG_NEG  = 0;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a sticky grant lock. Holds the priority
// pointer and the lock owner.
module rr_arb2
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic [1:0] elig,
  input  logic [1:0] lock,
  output logic [1:0] grant
);

  port_e ptr_q;
  port_e owner_q;
  logic  owned_q;
  port_e gnt_id;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
    grant = 2'b00;
    if (owned_q && elig[owner_q]) begin
      grant[owner_q] = 1'b1;
    end else if (elig == 2'b11) begin
      grant[ptr_q] = 1'b1;
    end else begin
      grant = elig;
    end
    gnt_id = grant[1] ? PORT1 : PORT0;
  end

  // NOTE: state registers use non-blocking assignments so all flops update from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= PORT0;
      owner_q <= PORT0;
      owned_q <= 1'b0;
    end else begin
      if (grant[1]) begin
        ptr_q <= PORT0;
      end else if (grant[0]) begin
        ptr_q <= PORT1;
      end

      // An owner stalled behind its full buffer keeps the lock; only a dropped
      // request or a lock-free grant releases it.
      if (owned_q) begin
        if (!valid[owner_q] || (grant[owner_q] && !lock[owner_q])) begin
          owned_q <= 1'b0;
        end
      end else if ((|grant) && lock[gnt_id]) begin
        owned_q <= 1'b1;
        owner_q <= gnt_id;
      end
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one combinational ALU between the execute stage (port 0) and the
// address/branch-target unit (port 1), buffering one result per requester.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int DW  = alu_pkg::ALU_DW,
  parameter int OPW = alu_pkg::ALU_OPW
) (
  input  logic           clk,
  input  logic           rst_n,

  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic           req0_lock,
  input  logic [OPW-1:0] req0_op,
  input  logic [1:0]     req0_lsb,
  input  logic [2:0]     req0_inv,
  input  logic [DW-1:0]  req0_a,
  input  logic [DW-1:0]  req0_b,

  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic           req1_lock,
  input  logic [OPW-1:0] req1_op,
  input  logic [1:0]     req1_lsb,
  input  logic [2:0]     req1_inv,
  input  logic [DW-1:0]  req1_a,
  input  logic [DW-1:0]  req1_b,

  output logic           rsp0_valid,
  input  logic           rsp0_ready,
  output logic [DW-1:0]  rsp0_data,
  output logic [2:0]     rsp0_flags,

  output logic           rsp1_valid,
  input  logic           rsp1_ready,
  output logic [DW-1:0]  rsp1_data,
  output logic [2:0]     rsp1_flags,

  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  output logic [OPW-1:0] alu_op,
  output logic [1:0]     alu_lsb,
  output logic [2:0]     alu_inv,
  input  logic [DW-1:0]  alu_out,
  input  logic [2:0]     alu_flags,

  output logic           busy
);

  logic [1:0]    elig;
  logic [1:0]    grant;
  logic [1:0]    rsp_ready;
  logic [1:0]    rsp_valid_q;
  logic [DW-1:0] rsp_data_q  [2];
  logic [2:0]    rsp_flags_q [2];

  assign rsp_ready = {rsp1_ready, rsp0_ready};

  // A full buffer being drained this cycle counts as free, so no bubble.
  assign elig[0] = req0_valid & (~rsp_valid_q[0] | rsp0_ready);
  assign elig[1] = req1_valid & (~rsp_valid_q[1] | rsp1_ready);

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .valid ({req1_valid, req0_valid}),
    .elig  (elig),
    .lock  ({req1_lock, req0_lock}),
    .grant (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign busy       = |grant;

  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_op  = OPW'(OP_NOP);
    alu_lsb = '0;
    alu_inv = '0;
    if (grant[0]) begin
      alu_a   = req0_a;
      alu_b   = req0_b;
      alu_op  = req0_op;
      alu_lsb = req0_lsb;
      alu_inv = req0_inv;
    end else if (grant[1]) begin
      alu_a   = req1_a;
      alu_b   = req1_b;
      alu_op  = req1_op;
      alu_lsb = req1_lsb;
      alu_inv = req1_inv;
    end
  end

  // NOTE: the result buffers are plain registers, so data is reset along with valid; nothing stale is visible after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        rsp_valid_q[i] <= 1'b0;
        rsp_data_q[i]  <= '0;
        rsp_flags_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (grant[i]) begin
          rsp_valid_q[i] <= 1'b1;
          rsp_data_q[i]  <= alu_out;
          rsp_flags_q[i] <= alu_flags;
        end else if (rsp_ready[i]) begin
          rsp_valid_q[i] <= 1'b0;
        end
      end
    end
  end

  assign rsp0_valid = rsp_valid_q[0];
  assign rsp0_data  = rsp_data_q[0];
  assign rsp0_flags = rsp_flags_q[0];
  assign rsp1_valid = rsp_valid_q[1];
  assign rsp1_data  = rsp_data_q[1];
  assign rsp1_flags = rsp_flags_q[1];

endmodule
